mem_resp: RTL and testbench

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_resp_pkg.sv | 32 +++
 rtl/mem_resp_fifo.sv | 52 +++++
 rtl/mem_resp.sv | 113 +++++++++++
 tb/tb_mem_resp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Address map, status byte layout and region decode shared by mem_resp and its FIFO.
package mem_resp_pkg;

  localparam logic [15:0] RAM_BASE       = 16'h0000;
  localparam logic [15:0] IO_DATA_ADDR   = 16'hF000;
  localparam logic [15:0] IO_STATUS_ADDR = 16'hF001;
  localparam logic [15:0] ROM_BASE       = 16'hFF00;
  localparam logic [15:0] VEC_LO         = 16'hFFFC;
  localparam logic [15:0] VEC_HI         = 16'hFFFD;
  localparam logic [7:0]  NOP_OPCODE     = 8'hEA;

  localparam int STAT_OVF_BIT   = 7;
  localparam int STAT_FULL_BIT  = 6;
  localparam int STAT_EMPTY_BIT = 5;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_IO_DATA,
    RGN_IO_STATUS,
    RGN_ROM,
    RGN_UNMAPPED
  } region_e;

  function automatic region_e decode_region(input logic [15:0] addr, input int ram_aw);
    if (32'(addr - RAM_BASE) < (32'd1 << ram_aw)) return RGN_RAM;
    else if (addr == IO_DATA_ADDR)                return RGN_IO_DATA;
    else if (addr == IO_STATUS_ADDR)              return RGN_IO_STATUS;
    else if (addr >= ROM_BASE)                    return RGN_ROM;
    else                                          return RGN_UNMAPPED;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Synchronous byte FIFO; push while full is accepted only when a pop frees a slot the same cycle.
// Head byte is combinational from the read pointer and reads as zero when empty.
module mem_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_dat,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/mem_resp.sv
// Processor memory responder: RAM, vector ROM, I/O byte FIFO with status, one-cycle registered reads.
// Optional ROM write-protect flag enabled by defining MEM_RESP_WPROT_EN.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int          RAM_AW       = 11,
  parameter logic [15:0] VECTOR_VALUE = 16'h0200,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  write_data,
  input  logic        write_enable,
  output logic [7:0]  read_data,
  output logic [7:0]  io_data,
  output logic        io_valid,
  input  logic        io_ready,
  output logic        wprot_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic [7:0]    r_ram [2**RAM_AW];
  logic [7:0]    r_read_data;
  logic          r_ovf;
  region_e       w_region;
  logic          w_push_req;
  logic          w_ovf_evt;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_status;
  logic [7:0]    w_rd_byte;

  // Assert asynchronously, release two edges after reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_region   = decode_region(address, RAM_AW);
  assign w_push_req = write_enable && (w_region == RGN_IO_DATA);
  assign w_ovf_evt  = w_push_req && w_full && !io_ready;

  mem_resp_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .i_push     (w_push_req),
    .i_push_dat (write_data),
    .i_pop      (io_ready),
    .o_head_dat (io_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  always_ff @(posedge clk) begin
    if (write_enable && (w_region == RGN_RAM)) r_ram[address[RAM_AW-1:0]] <= write_data;
  end

  always_comb begin
    w_status                 = '0;
    w_status[STAT_OVF_BIT]   = r_ovf;
    w_status[STAT_FULL_BIT]  = w_full;
    w_status[STAT_EMPTY_BIT] = w_empty;
    w_status[3:0]            = 4'(w_count);
  end

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_region)
      RGN_RAM:       w_rd_byte = r_ram[address[RAM_AW-1:0]];
      RGN_IO_STATUS: w_rd_byte = w_status;
      RGN_ROM: begin
        if (address == VEC_LO)      w_rd_byte = VECTOR_VALUE[7:0];
        else if (address == VEC_HI) w_rd_byte = VECTOR_VALUE[15:8];
        else                        w_rd_byte = NOP_OPCODE;
      end
      default:       w_rd_byte = 8'h00;
    endcase
  end

  // A status read clears overflow, but a drop in the same cycle keeps it set.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_read_data <= 8'h00;
      r_ovf       <= 1'b0;
    end else begin
      r_read_data <= w_rd_byte;
      if (w_ovf_evt)                        r_ovf <= 1'b1;
      else if (w_region == RGN_IO_STATUS)   r_ovf <= 1'b0;
    end
  end

`ifdef MEM_RESP_WPROT_EN
  logic r_wprot_err;
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)                                       r_wprot_err <= 1'b0;
    else if (write_enable && (w_region == RGN_ROM))     r_wprot_err <= 1'b1;
  end
  assign wprot_err = r_wprot_err;
`else
  assign wprot_err = 1'b0;
`endif

  assign read_data = r_read_data;
  assign io_valid  = !w_empty;

endmodule

// File: tb/tb_mem_resp.sv
// Randomized and directed bench for mem_resp against a queue/array reference model.
module tb_mem_resp;

  localparam int RAM_AW = 11;
  localparam int DEPTH  = 4;
`ifdef MEM_RESP_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  write_data;
  logic        write_enable;
  logic [7:0]  read_data;
  logic [7:0]  io_data;
  logic        io_valid;
  logic        io_ready;
  logic        wprot_err;

  mem_resp #(.RAM_AW(RAM_AW), .VECTOR_VALUE(16'h0200), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data    (read_data),
    .io_data      (io_data),
    .io_valid     (io_valid),
    .io_ready     (io_ready),
    .wprot_err    (wprot_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [7:0] ram_m [int];
  logic [7:0] q_m [$];
  bit         ovf_m;
  bit         wprot_m;
  logic [7:0] exp_rd;
  bit         exp_rd_known;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    ovf_m        = 1'b0;
    wprot_m      = 1'b0;
    exp_rd       = 8'h00;
    exp_rd_known = 1'b1;
  endtask

  // One clock edge of the specified behaviour, applied to the model's state.
  task automatic model_update(input logic [15:0] a, input logic we, input logic [7:0] wd, input logic rdy);
    int  n;
    bit  pop, push, drop;
    n = q_m.size();
    exp_rd_known = 1'b1;
    if (int'(a) < (1 << RAM_AW)) begin
      if (ram_m.exists(int'(a))) exp_rd = ram_m[int'(a)];
      else exp_rd_known = 1'b0;
    end else if (a == 16'hF001) exp_rd = {ovf_m, n == DEPTH, n == 0, 1'b0, 4'(n)};
    else if (a == 16'hFFFC) exp_rd = 8'h00;
    else if (a == 16'hFFFD) exp_rd = 8'h02;
    else if (a >= 16'hFF00) exp_rd = 8'hEA;
    else exp_rd = 8'h00;
    pop  = rdy && (n > 0);
    push = we && (a == 16'hF000);
    drop = push && (n == DEPTH) && !pop;
    if (pop) void'(q_m.pop_front());
    if (push && !drop) q_m.push_back(wd);
    if (drop) ovf_m = 1'b1;
    else if (a == 16'hF001) ovf_m = 1'b0;
    if (we && int'(a) < (1 << RAM_AW)) ram_m[int'(a)] = wd;
    if (WPROT && we && a >= 16'hFF00) wprot_m = 1'b1;
  endtask

  task automatic step(input logic [15:0] a, input logic we, input logic [7:0] wd, input logic rdy);
    @(negedge clk);
    address = a; write_enable = we; write_data = wd; io_ready = rdy;
    @(posedge clk);
    #1;
    model_update(a, we, wd, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'hE000, 1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_rd_known) cmp("read_data", read_data, exp_rd);
      cmp("io_valid", {7'b0, io_valid}, {7'b0, q_m.size() > 0});
      cmp("io_data", io_data, (q_m.size() > 0) ? q_m[0] : 8'h00);
      cmp("wprot_err", {7'b0, wprot_err}, {7'b0, wprot_m});
    end
  end

  initial begin
    reset = 1'b0; address = 16'hE000; write_data = 8'h00; write_enable = 1'b0; io_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    cmp("rst_read_data", read_data, 8'h00);
    cmp("rst_io_valid", {7'b0, io_valid}, 8'h00);
    cmp("rst_io_data", io_data, 8'h00);
    cmp("rst_wprot", {7'b0, wprot_err}, 8'h00);
    reset = 1'b1;
    idle(3);
    chk_en = 1'b1;

    step(16'hFFFC, 1'b0, 8'h00, 1'b0); cmp("vec_lo", read_data, 8'h00);
    step(16'hFFFD, 1'b0, 8'h00, 1'b0); cmp("vec_hi", read_data, 8'h02);
    step(16'hFF10, 1'b0, 8'h00, 1'b0); cmp("rom_nop", read_data, 8'hEA);
    step(16'h0800, 1'b0, 8'h00, 1'b0); cmp("unmapped", read_data, 8'h00);

    step(16'h0124, 1'b1, 8'h11, 1'b0);
    step(16'h0123, 1'b1, 8'h5A, 1'b0);
    step(16'h0123, 1'b0, 8'h00, 1'b0); cmp("ram_rd", read_data, 8'h5A);
    step(16'h0124, 1'b1, 8'h99, 1'b0); cmp("ram_rbw", read_data, 8'h11);
    step(16'h0124, 1'b0, 8'h00, 1'b0); cmp("ram_new", read_data, 8'h99);

    for (int i = 1; i <= 5; i++) step(16'hF000, 1'b1, 8'(i), 1'b0);
    step(16'hF001, 1'b0, 8'h00, 1'b0); cmp("stat_ovf", read_data, 8'hC4);
    step(16'hF001, 1'b0, 8'h00, 1'b0); cmp("stat_clr", read_data, 8'h44);
    step(16'hF000, 1'b1, 8'h77, 1'b1); cmp("full_pushpop_head", io_data, 8'h02);
    step(16'hF001, 1'b0, 8'h00, 1'b0); cmp("full_pushpop_stat", read_data, 8'h44);
    step(16'hE000, 1'b0, 8'h00, 1'b1); cmp("drain0", io_data, 8'h03);
    step(16'hE000, 1'b0, 8'h00, 1'b1); cmp("drain1", io_data, 8'h04);
    step(16'hE000, 1'b0, 8'h00, 1'b1); cmp("drain2", io_data, 8'h77);
    step(16'hE000, 1'b0, 8'h00, 1'b1); cmp("drain_empty", {7'b0, io_valid}, 8'h00);
    step(16'hF000, 1'b1, 8'hAB, 1'b1); cmp("empty_pushpop_vld", {7'b0, io_valid}, 8'h01);
    step(16'hF001, 1'b0, 8'h00, 1'b0); cmp("empty_pushpop_stat", read_data, 8'h01);

    step(16'hFFFC, 1'b1, 8'h00, 1'b0);
    step(16'hFFFC, 1'b0, 8'h00, 1'b0);
    cmp("wprot", {7'b0, wprot_err}, {7'b0, WPROT});
    cmp("vec_lo_after_wr", read_data, 8'h00);
    step(16'hFFFD, 1'b0, 8'h00, 1'b0); cmp("vec_hi_after_wr", read_data, 8'h02);

    for (int i = 0; i < 16; i++) step(16'h0120 + 16'(i), 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 1500; i++) begin
      int k;
      logic [15:0] a;
      logic we;
      k  = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      case (k)
        0, 1, 2: a = 16'h0120 + 16'($urandom_range(0, 15));
        3, 4: begin a = 16'hF000; we = ($urandom_range(0, 3) != 0); end
        5:    a = 16'hF001;
        6:    a = 16'hFF00 | 16'($urandom_range(0, 255));
        7:    a = 16'hFFFC + 16'($urandom_range(0, 1));
        8:    a = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(16'h0800, 16'hEFFF))
                                              : 16'($urandom_range(16'hF002, 16'hFEFF));
        default: a = 16'($urandom_range(0, (1 << RAM_AW) - 1));
      endcase
      step(a, we, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    step(16'h0130, 1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) step(16'hF000, 1'b1, 8'hC0 + 8'(i), 1'b0);
    @(negedge clk);
    address = 16'hF000; write_enable = 1'b1; write_data = 8'hEE; io_ready = 1'b0;
    #2;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    cmp("midrst_io_valid", {7'b0, io_valid}, 8'h00);
    cmp("midrst_io_data", io_data, 8'h00);
    cmp("midrst_read_data", read_data, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    address = 16'hE000; write_enable = 1'b0;
    reset = 1'b1;
    idle(3);
    chk_en = 1'b1;
    step(16'hF001, 1'b0, 8'h00, 1'b0); cmp("post_rst_stat", read_data, 8'h20);
    step(16'h0130, 1'b0, 8'h00, 1'b0); cmp("ram_retained", read_data, 8'h3C);
    cmp("post_rst_wprot", {7'b0, wprot_err}, 8'h00);
    idle(2);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
